bootrom_loader: RTL and testbench

- Boot-time copy engine directly downstream of the 256-byte boot ROM.
- Walks the ROM two bytes at a time and writes each 16-bit little-endian word into main memory at a configurable base address.
- Holds the CPU in reset until the copy completes, then releases it.
- Sits between the boot ROM, the memory write port and the CPU reset input.

---
 rtl/bootrom_loader_pkg.sv | 26 ++
 rtl/bootrom_loader_if.sv | 23 ++
 rtl/bootrom_loader.sv | 128 ++++++++++++
 tb/tb_bootrom_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bootrom_loader_pkg.sv
// Shared types and widths for the boot ROM copy engine.
package bootrom_loader_pkg;

    localparam int ROM_AW = 8;
    localparam int MEM_AW = 16;
    localparam int MEM_DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Byte offset of a 16-bit word inside the ROM (always even).
    function automatic logic [ROM_AW-1:0] rom_byte_addr(input logic [ROM_AW-2:0] idx);
        return {idx, 1'b0};
    endfunction

    // Byte offset of a word in destination memory, before adding the base.
    function automatic logic [MEM_AW-1:0] mem_byte_off(input logic [ROM_AW-1:0] idx);
        return {{(MEM_AW-ROM_AW-1){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/bootrom_loader_if.sv
// ROM read port and memory write port of the boot ROM copy engine.
interface bootrom_loader_if;
    import bootrom_loader_pkg::*;

    logic              O_rom_enable;
    logic [ROM_AW-1:0] O_rom_addr;
    logic [MEM_DW-1:0] I_rom_data;
    logic [MEM_AW-1:0] O_mem_addr;
    logic [MEM_DW-1:0] O_mem_data;
    logic              O_mem_we;
    logic              I_mem_ready;

    modport master (
        output O_rom_enable, O_rom_addr, O_mem_addr, O_mem_data, O_mem_we,
        input  I_rom_data, I_mem_ready
    );

    modport slave (
        input  O_rom_enable, O_rom_addr, O_mem_addr, O_mem_data, O_mem_we,
        output I_rom_data, I_mem_ready
    );

endinterface

// File: rtl/bootrom_loader.sv
// Copies the boot ROM word-by-word into main memory, holding the CPU in reset until done.
// Optional running checksum of accepted words: define BOOTROM_LOADER_CHECKSUM_EN.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | waiting for I_start, CPU held in reset
//  FETCH   | ROM read enable high for the current word
//  CAPTURE | ROM word latched into the write data/address registers
//  WRITE   | write request held until memory accepts it
//  DONE    | copy complete, CPU released; left only by reset
module bootrom_loader
    import bootrom_loader_pkg::*;
#(
    parameter int                ROM_BYTES = 256,
    parameter logic [MEM_AW-1:0] DEST_BASE = 16'h0000
) (
    input  logic I_clk,
    input  logic I_reset_n,
    input  logic I_start,
    bootrom_loader_if.master bus,
    output logic O_busy,
    output logic O_done,
    output logic O_cpu_reset
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    ,
    output logic [MEM_DW-1:0] O_checksum
`endif
);

    localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(ROM_BYTES / 2 - 1);

    state_t            state_q;
    logic [ROM_AW-1:0] count_q;
    logic [ROM_AW-1:0] count_d;
    logic              rom_en_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [MEM_DW-1:0] mem_data_q;
    logic              mem_we_q;
    logic              busy_q;
    logic              done_q;
    logic              cpu_reset_q;
    logic              accept;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    logic [MEM_DW-1:0] checksum_q;
`endif

    assign count_d = count_q + 1'b1;
    assign accept  = mem_we_q & bus.I_mem_ready;

    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (I_start) begin
                        state_q    <= ST_FETCH;
                        busy_q     <= 1'b1;
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= rom_byte_addr(count_q[ROM_AW-2:0]);
                    end
                end
                ST_FETCH: begin
                    rom_en_q <= 1'b0;
                    state_q  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    mem_data_q <= bus.I_rom_data;
                    mem_addr_q <= DEST_BASE + mem_byte_off(count_q);
                    mem_we_q   <= 1'b1;
                    state_q    <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (accept) begin
                        mem_we_q <= 1'b0;
                        count_q  <= count_d;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
                        checksum_q <= checksum_q + mem_data_q;
`endif
                        // Flags flip on the accepting edge so busy ends with the last write.
                        if (count_q == LAST_IDX) begin
                            state_q     <= ST_DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q    <= ST_FETCH;
                            rom_en_q   <= 1'b1;
                            rom_addr_q <= rom_byte_addr(count_d[ROM_AW-2:0]);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.O_rom_enable = rom_en_q;
    assign bus.O_rom_addr   = rom_addr_q;
    assign bus.O_mem_addr   = mem_addr_q;
    assign bus.O_mem_data   = mem_data_q;
    assign bus.O_mem_we     = mem_we_q;
    assign O_busy           = busy_q;
    assign O_done           = done_q;
    assign O_cpu_reset      = cpu_reset_q;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    assign O_checksum       = checksum_q;
`endif

endmodule

// File: tb/tb_bootrom_loader.sv
// Directed bench for bootrom_loader: full copy, backpressure, mid-copy reset, ignored start, wrap.
module tb_bootrom_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic busy_a, done_a, cpu_rst_a;
    logic busy_b, done_b, cpu_rst_b;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    logic [15:0] csum_a, csum_b;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit rom_pat = 1'b0;
    bit bp_en = 1'b0;
    bit hold_en = 1'b0;
    int stall_cnt = 0;
    int stab_err = 0;

    logic [15:0] wa_a [0:2047];
    logic [15:0] wd_a [0:2047];
    logic [7:0]  ra_a [0:2047];
    int nw_a = 0;
    int nr_a = 0;
    logic [15:0] wa_b [0:63];
    logic [15:0] wd_b [0:63];
    int nw_b = 0;
    int nr_b = 0;
    logic [7:0] max_ra_b = 8'h00;

    bootrom_loader_if bus_a ();
    bootrom_loader_if bus_b ();

    bootrom_loader #(.ROM_BYTES(256), .DEST_BASE(16'h0100)) dut_a (
        .I_clk(clk), .I_reset_n(rst_n), .I_start(start_a), .bus(bus_a),
        .O_busy(busy_a), .O_done(done_a), .O_cpu_reset(cpu_rst_a)
`ifdef BOOTROM_LOADER_CHECKSUM_EN
        , .O_checksum(csum_a)
`endif
    );

    bootrom_loader #(.ROM_BYTES(8), .DEST_BASE(16'hFFFC)) dut_b (
        .I_clk(clk), .I_reset_n(rst_n), .I_start(start_b), .bus(bus_b),
        .O_busy(busy_b), .O_done(done_b), .O_cpu_reset(cpu_rst_b)
`ifdef BOOTROM_LOADER_CHECKSUM_EN
        , .O_checksum(csum_b)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_word(input bit pat, input logic [7:0] a);
        logic [7:0] hi;
        hi = a + 8'd1;
        if (pat) return 16'h0101;
        return {hi, a};
    endfunction

    // ROM models (one-cycle read latency) and write/read loggers.
    always @(posedge clk) begin
        if (bus_a.O_rom_enable) begin
            bus_a.I_rom_data <= rom_word(rom_pat, bus_a.O_rom_addr);
            ra_a[nr_a] <= bus_a.O_rom_addr;
            nr_a <= nr_a + 1;
        end
        if (rst_n && bus_a.O_mem_we && bus_a.I_mem_ready) begin
            wa_a[nw_a] <= bus_a.O_mem_addr;
            wd_a[nw_a] <= bus_a.O_mem_data;
            nw_a <= nw_a + 1;
        end
    end

    always @(posedge clk) begin
        if (bus_b.O_rom_enable) begin
            bus_b.I_rom_data <= rom_word(rom_pat, bus_b.O_rom_addr);
            if (bus_b.O_rom_addr > max_ra_b) max_ra_b <= bus_b.O_rom_addr;
            nr_b <= nr_b + 1;
        end
        if (rst_n && bus_b.O_mem_we && bus_b.I_mem_ready) begin
            wa_b[nw_b] <= bus_b.O_mem_addr;
            wd_b[nw_b] <= bus_b.O_mem_data;
            nw_b <= nw_b + 1;
        end
    end

    assign bus_b.I_mem_ready = 1'b1;

    // Memory ready for DUT A: stalls the word at 0x0104 four cycles, or holds word 10 forever.
    always @(negedge clk) begin
        if (hold_en && bus_a.O_mem_we && bus_a.O_mem_addr == 16'h0114) begin
            bus_a.I_mem_ready <= 1'b0;
        end else if (bp_en && bus_a.O_mem_we && bus_a.O_mem_addr == 16'h0104 && stall_cnt < 4) begin
            bus_a.I_mem_ready <= 1'b0;
            stall_cnt <= stall_cnt + 1;
            if (bus_a.O_mem_data !== 16'h0504 || bus_a.O_rom_enable !== 1'b0)
                stab_err <= stab_err + 1;
        end else begin
            bus_a.I_mem_ready <= 1'b1;
        end
        if (!bp_en) stall_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_rom_en"},   {31'd0, bus_a.O_rom_enable}, 32'd0);
        check({tag, "_rom_addr"}, {24'd0, bus_a.O_rom_addr},   32'd0);
        check({tag, "_mem_addr"}, {16'd0, bus_a.O_mem_addr},   32'd0);
        check({tag, "_mem_data"}, {16'd0, bus_a.O_mem_data},   32'd0);
        check({tag, "_mem_we"},   {31'd0, bus_a.O_mem_we},     32'd0);
        check({tag, "_busy"},     {31'd0, busy_a},             32'd0);
        check({tag, "_done"},     {31'd0, done_a},             32'd0);
        check({tag, "_cpu_rst"},  {31'd0, cpu_rst_a},          32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Pulses start, optionally re-pulses it dup_at cycles in, returns edges from start edge to done.
    task automatic run_copy(input bit use_b, input int dup_at, output int cycles);
        int  start_cyc;
        bit  seen;
        @(posedge clk); #1;
        start_cyc = cyc;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        seen = 1'b0;
        cycles = -1;
        for (int k = 0; k < 2000 && !seen; k++) begin
            if (k == dup_at) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if ((use_b ? done_b : done_a) === 1'b1) begin
                seen = 1'b1;
                cycles = cyc - start_cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check("done_reached", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int cycles;
        int wbase, rbase, errs, seen;
        logic [15:0] exp_a, exp_d;

        bus_a.I_mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_a("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Full copy, memory always ready, with a spurious start mid-copy.
        wbase = nw_a;
        rbase = nr_a;
        run_copy(1'b0, 50, cycles);
        check("run1_cycles", cycles, 385);
        check("run1_writes", nw_a - wbase, 128);
        check("run1_reads", nr_a - rbase, 128);
        check("run1_first_addr", {16'd0, wa_a[wbase]}, 32'h0100);
        check("run1_first_data", {16'd0, wd_a[wbase]}, 32'h0100);
        check("run1_last_addr", {16'd0, wa_a[wbase + 127]}, 32'h01FE);
        check("run1_last_data", {16'd0, wd_a[wbase + 127]}, 32'hFFFE);
        errs = 0;
        for (int i = 0; i < 128; i++) begin
            exp_a = 16'h0100 + 16'(2 * i);
            exp_d = {8'(2 * i + 1), 8'(2 * i)};
            if (wa_a[wbase + i] !== exp_a || wd_a[wbase + i] !== exp_d || ra_a[rbase + i] !== 8'(2 * i))
                errs++;
        end
        check("run1_all_words", errs, 0);
        check("run1_cpu_rst", {31'd0, cpu_rst_a}, 32'd0);
        check("run1_busy", {31'd0, busy_a}, 32'd0);

        // Start after done is ignored.
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("post_done_done", {31'd0, done_a}, 32'd1);
        check("post_done_busy", {31'd0, busy_a}, 32'd0);
        check("post_done_reads", nr_a - rbase, 128);
        check("post_done_writes", nw_a - wbase, 128);
        check("post_done_cpu_rst", {31'd0, cpu_rst_a}, 32'd0);

        // Destination address wrap on the 8-byte instance.
        run_copy(1'b1, -1, cycles);
        check("wrap_cycles", cycles, 13);
        check("wrap_writes", nw_b, 4);
        check("wrap_reads", nr_b, 4);
        check("wrap_max_rom_addr", {24'd0, max_ra_b}, 32'd6);
        check("wrap_a0", {16'd0, wa_b[0]}, 32'hFFFC);
        check("wrap_a1", {16'd0, wa_b[1]}, 32'hFFFE);
        check("wrap_a2", {16'd0, wa_b[2]}, 32'h0000);
        check("wrap_a3", {16'd0, wa_b[3]}, 32'h0002);
        check("wrap_d3", {16'd0, wd_b[3]}, 32'h0706);

        // Backpressure on the third write.
        do_reset();
        check_reset_a("bp_rst");
        @(negedge clk);
        rst_n = 1'b1;
        bp_en = 1'b1;
        wbase = nw_a;
        rbase = nr_a;
        run_copy(1'b0, -1, cycles);
        check("bp_cycles", cycles, 389);
        check("bp_stalls", stall_cnt, 4);
        check("bp_stable", stab_err, 0);
        check("bp_reads", nr_a - rbase, 128);
        check("bp_third_addr", {16'd0, wa_a[wbase + 2]}, 32'h0104);
        check("bp_third_data", {16'd0, wd_a[wbase + 2]}, 32'h0504);
        bp_en = 1'b0;

        // Reset while word 10 is waiting in WRITE.
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold_en = 1'b1;
        wbase = nw_a;
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        seen = 0;
        for (int k = 0; k < 200 && seen == 0; k++) begin
            if (bus_a.O_mem_we === 1'b1 && bus_a.O_mem_addr === 16'h0114) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check("mid_word10_reached", seen, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_a("mid_rst");
        check("mid_writes", nw_a - wbase, 10);
        @(negedge clk);
        rst_n = 1'b1;
        hold_en = 1'b0;
        wbase = nw_a;
        rbase = nr_a;
        run_copy(1'b0, -1, cycles);
        check("restart_cycles", cycles, 385);
        check("restart_first_rom", {24'd0, ra_a[rbase]}, 32'd0);
        check("restart_writes", nw_a - wbase, 128);
        check("restart_first_addr", {16'd0, wa_a[wbase]}, 32'h0100);

`ifdef BOOTROM_LOADER_CHECKSUM_EN
        do_reset();
        check("csum_rst", {16'd0, csum_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rom_pat = 1'b1;
        run_copy(1'b0, -1, cycles);
        check("csum_final", {16'd0, csum_a}, 32'h8080);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
